// File: rtl/conn_pkg.sv
// Shared connection-table types: default geometry, index layout, reverse-lookup FSM states.
// No logic latency; combinational hash helper only.
// No flow control here; consumers own their handshakes.
package conn_pkg;

    localparam int KEY_WIDTH_DEF  = 32;
    localparam int WAYS_DEF       = 4;
    localparam int HASH_WIDTH_DEF = 16;
    localparam int WAYS_LOG_DEF   = $clog2(WAYS_DEF);

    typedef struct packed {
        logic [WAYS_LOG_DEF-1:0]   way;
        logic [HASH_WIDTH_DEF-1:0] hash;
    } conn_idx_t;

    typedef enum logic {
        RV_INIT,
        RV_RUN
    } rv_state_t;

    // Folds a 32-bit key into a set index for the forward lookup path.
    function automatic logic [15:0] xor32to16(input logic [31:0] v);
        return v[31:16] ^ v[15:0];
    endfunction

endpackage

// File: rtl/conn_rsp_fifo.sv
// Synchronous response FIFO carrying {hit,key}, with occupancy count for upstream credit.
// Latency: push visible at pop_dat one cycle later; pop_dat is the head, held until popped.
// Push into a full FIFO or pop from an empty one is ignored; the caller reserves space.
module conn_rsp_fifo #(
    parameter int  DW    = 33,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_nxt(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_nxt(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/dual_port_bram.sv
// Simple dual-port RAM: port A write, port B registered read (read-first on collision).
// Latency: 1 cycle from b_addr to b_dout.
// No backpressure; accepts a write and a read every cycle.
module dual_port_bram #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    input  logic [AW-1:0] b_addr,
    output logic [DW-1:0] b_dout
);

    logic [DW-1:0] mem [1<<AW];

    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_din;
        b_dout <= mem[b_addr];
    end

endmodule

// File: rtl/conn_reverse_lookup.sv
// Maps connection index {way,hash} back to its key; table mirrored from activate/deactivate updates.
// Latency: 3 cycles accept->response (addr reg, BRAM out reg, FIFO); one lookup per cycle.
// Backpressure: request ready reserves FIFO space for in-flight reads; RV_LOOKUP_STATS_EN adds hit/miss counters.
module conn_reverse_lookup
    import conn_pkg::*;
#(
    parameter int  KEY_WIDTH  = KEY_WIDTH_DEF,
    parameter int  WAYS       = WAYS_DEF,
    parameter int  HASH_WIDTH = HASH_WIDTH_DEF,
    parameter int  FIFO_DEPTH = 4,
    localparam int WAYS_LOG   = $clog2(WAYS),
    localparam int IDX_WIDTH  = HASH_WIDTH + WAYS_LOG
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s00_axis_rv_lookup_valid,
    input  logic [IDX_WIDTH-1:0] s00_axis_rv_lookup_idx,
    output logic                 s00_axis_rv_lookup_ready,
    output logic                 m00_axis_rv_lookup_valid,
    input  logic                 m00_axis_rv_lookup_ready,
    output logic                 m00_axis_rv_lookup_hit,
    output logic [KEY_WIDTH-1:0] m00_axis_rv_lookup_key,
    input  logic                 s01_axis_upd_valid,
    input  logic [IDX_WIDTH-1:0] s01_axis_upd_idx,
    input  logic [KEY_WIDTH-1:0] s01_axis_upd_key,
    input  logic                 s01_axis_upd_activate,
    output logic                 s01_axis_upd_ready,
    output logic                 init_done
`ifdef RV_LOOKUP_STATS_EN
    ,
    output logic [31:0]          stat_hits,
    output logic [31:0]          stat_misses
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    function automatic logic way_ok(input logic [WAYS_LOG-1:0] w);
        if ((1 << WAYS_LOG) == WAYS) return 1'b1;
        return int'(w) < WAYS;
    endfunction

    rv_state_t             state_q, state_d;
    logic [HASH_WIDTH-1:0] init_addr;
    logic                  in_init;

    assign in_init   = (state_q == RV_INIT);
    assign init_done = (state_q == RV_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RV_INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (in_init && (&init_addr)) state_d = RV_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       init_addr <= '0;
        else if (in_init) init_addr <= init_addr + 1'b1;
    end

    logic [WAYS_LOG-1:0]   upd_way;
    logic [HASH_WIDTH-1:0] upd_hash;
    logic                  upd_ok;
    logic [KEY_WIDTH-1:0]  upd_key_eff;

    assign s01_axis_upd_ready = init_done;
    assign upd_way     = s01_axis_upd_idx[IDX_WIDTH-1:HASH_WIDTH];
    assign upd_hash    = s01_axis_upd_idx[HASH_WIDTH-1:0];
    assign upd_ok      = s01_axis_upd_valid && s01_axis_upd_ready && way_ok(upd_way);
    assign upd_key_eff = s01_axis_upd_activate ? s01_axis_upd_key : '0;

    logic [CW-1:0]        fifo_count;
    logic [CW:0]          occ;
    logic                 lk_fire, rsp_pop;
    logic                 p1_vld, p2_vld;
    logic [IDX_WIDTH-1:0] p1_idx, p2_idx;
    logic                 p2_fwd, p2_fwd_hit;
    logic [KEY_WIDTH-1:0] p2_fwd_key;

    // Slots already in flight count against FIFO space so no response can be dropped.
    assign occ = (CW+1)'(fifo_count) + (CW+1)'(p1_vld) + (CW+1)'(p2_vld);
    assign s00_axis_rv_lookup_ready = init_done && (occ < (CW+1)'(FIFO_DEPTH));
    assign lk_fire = s00_axis_rv_lookup_valid && s00_axis_rv_lookup_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_vld     <= 1'b0;
            p1_idx     <= '0;
            p2_vld     <= 1'b0;
            p2_idx     <= '0;
            p2_fwd     <= 1'b0;
            p2_fwd_hit <= 1'b0;
            p2_fwd_key <= '0;
        end else begin
            p1_vld <= lk_fire;
            if (lk_fire) p1_idx <= s00_axis_rv_lookup_idx;
            p2_vld <= p1_vld;
            p2_idx <= p1_idx;
            // The BRAM read on this edge sees the old contents, so capture a same-edge update.
            p2_fwd     <= upd_ok && (s01_axis_upd_idx == p1_idx);
            p2_fwd_hit <= s01_axis_upd_activate;
            p2_fwd_key <= upd_key_eff;
        end
    end

    logic [KEY_WIDTH-1:0] key_rd [WAYS];
    logic                 vld_rd [WAYS];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic sel;
        assign sel = upd_ok && (upd_way == WAYS_LOG'(w));

        dual_port_bram #(.DW(KEY_WIDTH), .AW(HASH_WIDTH)) u_key_bram (
            .clk    (clk),
            .a_we   (sel),
            .a_addr (upd_hash),
            .a_din  (upd_key_eff),
            .b_addr (p1_idx[HASH_WIDTH-1:0]),
            .b_dout (key_rd[w])
        );

        dual_port_bram #(.DW(1), .AW(HASH_WIDTH)) u_vld_bram (
            .clk    (clk),
            .a_we   (in_init || sel),
            .a_addr (in_init ? init_addr : upd_hash),
            .a_din  (!in_init && s01_axis_upd_activate),
            .b_addr (p1_idx[HASH_WIDTH-1:0]),
            .b_dout (vld_rd[w])
        );
    end

    logic [WAYS_LOG-1:0]  p2_way;
    logic                 rsp_hit;
    logic [KEY_WIDTH-1:0] rsp_key;

    assign p2_way = p2_idx[IDX_WIDTH-1:HASH_WIDTH];

    always_comb begin
        rsp_hit = 1'b0;
        rsp_key = '0;
        if (upd_ok && (s01_axis_upd_idx == p2_idx)) begin
            rsp_hit = s01_axis_upd_activate;
            rsp_key = upd_key_eff;
        end else if (p2_fwd) begin
            rsp_hit = p2_fwd_hit;
            rsp_key = p2_fwd_key;
        end else if (way_ok(p2_way)) begin
            rsp_hit = vld_rd[p2_way];
            rsp_key = rsp_hit ? key_rd[p2_way] : '0;
        end
    end

    logic [KEY_WIDTH:0] head_dat;

    assign rsp_pop = m00_axis_rv_lookup_valid && m00_axis_rv_lookup_ready;

    conn_rsp_fifo #(.DW(KEY_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (p2_vld),
        .push_dat ({rsp_hit, rsp_key}),
        .pop      (rsp_pop),
        .pop_dat  (head_dat),
        .count    (fifo_count)
    );

    assign m00_axis_rv_lookup_valid = (fifo_count != '0);
    assign m00_axis_rv_lookup_hit   = m00_axis_rv_lookup_valid && head_dat[KEY_WIDTH];
    assign m00_axis_rv_lookup_key   = m00_axis_rv_lookup_valid ? head_dat[KEY_WIDTH-1:0] : '0;

`ifdef RV_LOOKUP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (in_init) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (rsp_pop) begin
            if (m00_axis_rv_lookup_hit && (stat_hits != '1))    stat_hits   <= stat_hits + 1'b1;
            if (!m00_axis_rv_lookup_hit && (stat_misses != '1)) stat_misses <= stat_misses + 1'b1;
        end
    end
`endif

endmodule
